// File: rtl/shift_seq_pkg.sv
// Shared types and default widths for the shift sequencer / arbiter slice.
package shift_seq_pkg;

    localparam int NUM_REQ    = 2;
    localparam int W_AMT_DEF  = 4;
    localparam int PACE_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester other than last_gnt wins.
module rr_arb2
    import shift_seq_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/shift_seq_arbiter.sv
// Shares one shift datapath between two requesters: grant, load pulse, amt shift pulses, ready.
// Optional macro SHIFT_SEQ_PACE_EN spaces shift pulses by the pace value latched at grant.
module shift_seq_arbiter
    import shift_seq_pkg::*;
#(
    parameter int W_AMT  = W_AMT_DEF,
    parameter int PACE_W = PACE_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               En,
    input  logic [1:0]         req,
    input  logic [W_AMT-1:0]   m0,
    input  logic [W_AMT-1:0]   m1,
    input  logic [PACE_W-1:0]  pace,
    output logic [1:0]         gnt,
    output logic               sel,
    output logic               loadEn,
    output logic               shifterEn,
    output logic [1:0]         ready,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [W_AMT-1:0]   amt_q, amt_d;
    logic [W_AMT-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [1:0]         arb_gnt;
    logic               step_tick;

    rr_arb2 u_arb (
        .req      (req),
        .last_gnt (last_q),
        .gnt      (arb_gnt)
    );

`ifdef SHIFT_SEQ_PACE_EN
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic [PACE_W-1:0]  pcnt_q, pcnt_d;

    // A step fires once the pace counter has idled for pace cycles.
    assign step_tick = (pcnt_q == pace_q);
`else
    logic               unused_pace;

    assign unused_pace = ^pace;
    assign step_tick   = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
`ifdef SHIFT_SEQ_PACE_EN
            pace_q  <= '0;
            pcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
`ifdef SHIFT_SEQ_PACE_EN
            pace_q  <= pace_d;
            pcnt_q  <= pcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
`ifdef SHIFT_SEQ_PACE_EN
        pace_d  = pace_q;
        pcnt_d  = pcnt_q;
`endif
        if (En) begin
            case (state_q)
                IDLE: begin
                    if (|arb_gnt) begin
                        gnt_d   = arb_gnt;
                        amt_d   = arb_gnt[1] ? m1 : m0;
`ifdef SHIFT_SEQ_PACE_EN
                        pace_d  = pace;
`endif
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
`ifdef SHIFT_SEQ_PACE_EN
                    pcnt_d  = '0;
`endif
                    state_d = (amt_q == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
`ifdef SHIFT_SEQ_PACE_EN
                    pcnt_d = step_tick ? '0 : pcnt_q + PACE_W'(1);
`endif
                    if (step_tick) begin
                        cnt_d = cnt_q + W_AMT'(1);
                        if (cnt_q == amt_q - W_AMT'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    last_d  = gnt_q[1];
                    gnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt       = gnt_q;
        sel       = gnt_q[1];
        busy      = (state_q != IDLE);
        loadEn    = En && (state_q == LOAD);
        shifterEn = En && (state_q == SHIFT) && step_tick;
        ready     = (En && (state_q == DONE)) ? gnt_q : 2'b00;
    end

endmodule
